// File: rtl/mu0_pkg.sv
// mu0_pkg
// Definitions shared by the MU0 indexed-CPU system:
//   - MU0 opcode constants (4-bit instruction field)
//   - memory controller FSM state encoding
//   - even-parity helper used by the parity-protected memory build
package mu0_pkg;

    localparam int OPC_W = 4;

    // Base MU0 instruction set
    localparam logic [OPC_W-1:0] LDA    = 4'h0;
    localparam logic [OPC_W-1:0] STO    = 4'h1;
    localparam logic [OPC_W-1:0] ADD    = 4'h2;
    localparam logic [OPC_W-1:0] SUB    = 4'h3;
    localparam logic [OPC_W-1:0] JMP    = 4'h4;
    localparam logic [OPC_W-1:0] JGE    = 4'h5;
    localparam logic [OPC_W-1:0] JNE    = 4'h6;
    localparam logic [OPC_W-1:0] STP    = 4'h7;
    // Indexed extensions
    localparam logic [OPC_W-1:0] MOVI   = 4'h8;
    localparam logic [OPC_W-1:0] MOVIDX = 4'h9;
    localparam logic [OPC_W-1:0] SUBIDX = 4'hA;
    localparam logic [OPC_W-1:0] LDIDX  = 4'hB;
    localparam logic [OPC_W-1:0] ADDIDX = 4'hC;
    localparam logic [OPC_W-1:0] STIDX  = 4'hD;
    localparam logic [OPC_W-1:0] STOIDX = 4'hE;
    localparam logic [OPC_W-1:0] BUBIDX = 4'hF;

    // Memory controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Even-parity bit: the stored word plus this bit has an even number of ones.
    // Callers zero-extend narrower words; zeros do not change the result.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mu0_sram_core.sv
// mu0_sram_core
// DEPTH x WIDTH single-port storage array with synchronous write and a
// registered synchronous read. Maps onto block RAM; the array and the read
// register are not reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable, writes wdata to addr
//   re     - read enable, loads rdata from addr
//   addr   - word address (only asserted with in-range addresses)
//   wdata  - write word
//   rdata  - registered read word, holds between reads
module mu0_sram_core #(
    parameter int WIDTH = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mu0_wait_mem.sv
// mu0_wait_mem
// Wait-state memory for the MU0 indexed CPU. A request is accepted in IDLE,
// counts down RD_LAT/WR_LAT wait states, performs the access on the edge that
// leaves WAIT, then presents a one-cycle ready (with err) in RESP.
// Optional feature macro: MEM_PARITY_EN (per-word even parity, adds inj_par_err).
// Ports:
//   clk          - clock, rising edge
//   rst_n        - asynchronous active-low reset, aborts any transaction
//   inj_par_err  - (MEM_PARITY_EN only) store inverted parity on this write
//   req          - access request, sampled in IDLE only
//   rnw          - 1 = read, 0 = write, sampled on acceptance
//   addr         - word address, sampled on acceptance
//   wdata        - write data, sampled on acceptance
//   rdata        - read data, holds until the next read completes
//   ready        - one-cycle completion pulse
//   busy         - transaction in flight
//   err          - with ready: out-of-range address (or parity mismatch)
module mu0_wait_mem
    import mu0_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MEM_PARITY_EN
    input  logic              inj_par_err,
`endif
    input  logic              req,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int CORE_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    // One extra bit so DEPTH = 2**ADDR_W is representable; the compare then
    // folds to constant false.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      RD_CNT    = 4'(RD_LAT);
    localparam logic [3:0]      WR_CNT    = 4'(WR_LAT);

    mem_state_t        state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              rnw_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              oor_reg;
    // Set by an in-range read, cleared by an out-of-range read or reset;
    // selects between the array read register and zero.
    logic              rd_valid_reg;
`ifdef MEM_PARITY_EN
    logic              inj_reg;
`endif

    logic              access;
    logic              mem_we;
    logic              mem_re;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;
    logic              par_err;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = WAIT;
            WAIT:    if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The access happens exactly on the WAIT->RESP edge.
    assign access = (state_reg == WAIT) && (cnt_reg == 4'd0);
    assign mem_we = access && !rnw_reg && !oor_reg;
    assign mem_re = access &&  rnw_reg && !oor_reg;

    // ---------------- request capture / wait counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            rnw_reg      <= 1'b0;
            wdata_reg    <= '0;
            oor_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
`ifdef MEM_PARITY_EN
            inj_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        addr_reg  <= addr;
                        rnw_reg   <= rnw;
                        wdata_reg <= wdata;
                        oor_reg   <= ({1'b0, addr} >= DEPTH_EXT);
                        cnt_reg   <= rnw ? RD_CNT : WR_CNT;
`ifdef MEM_PARITY_EN
                        inj_reg   <= inj_par_err;
`endif
                    end
                end
                WAIT: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: ;
            endcase

            if (access && rnw_reg) begin
                rd_valid_reg <= !oor_reg;
            end
        end
    end

    // ---------------- storage ----------------
`ifdef MEM_PARITY_EN
    assign mem_wdata = {even_parity(64'(wdata_reg)) ^ inj_reg, wdata_reg};
`else
    assign mem_wdata = wdata_reg;
`endif

    mu0_sram_core #(
        .WIDTH (MEM_W),
        .AW    (CORE_AW),
        .DEPTH (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_reg[CORE_AW-1:0]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

`ifdef MEM_PARITY_EN
    // Checked in RESP against the word just read; rdata is still returned.
    assign par_err = rnw_reg && rd_valid_reg &&
                     (mem_rdata[DATA_W] != even_parity(64'(mem_rdata[DATA_W-1:0])));
`else
    assign par_err = 1'b0;
`endif

    // ---------------- outputs ----------------
    assign rdata = rd_valid_reg ? mem_rdata[DATA_W-1:0] : '0;
    assign ready = (state_reg == RESP);
    assign busy  = (state_reg != IDLE);
    assign err   = (state_reg == RESP) && (oor_reg || par_err);

endmodule

// File: tb/tb_mu0_wait_mem.sv
// tb_mu0_wait_mem
// Two instances share clock and reset:
//   inst 0 (u_a): defaults, DEPTH=4096, RD_LAT=2, WR_LAT=1
//   inst 1 (u_b): DEPTH=256, RD_LAT=0, WR_LAT=1
// Expected values come from an associative-array memory model plus the
// latency rule "ready visible after edge E0+LAT+1".
module tb_mu0_wait_mem;

`ifdef MEM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_req, a_rnw, a_ready, a_busy, a_err;
    logic [11:0] a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        b_req, b_rnw, b_ready, b_busy, b_err;
    logic [11:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
`ifdef MEM_PARITY_EN
    logic        a_inj, b_inj;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [15:0] mem_a [int];
    logic [15:0] mem_b [int];
    bit          bad_a [int];
    bit          bad_b [int];
    int          wr_a [$];
    int          wr_b [$];
    logic [15:0] hold_rd [2];

    always #5 clk = ~clk;

    mu0_wait_mem u_a (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MEM_PARITY_EN
        .inj_par_err (a_inj),
`endif
        .req         (a_req),
        .rnw         (a_rnw),
        .addr        (a_addr),
        .wdata       (a_wdata),
        .rdata       (a_rdata),
        .ready       (a_ready),
        .busy        (a_busy),
        .err         (a_err)
    );

    mu0_wait_mem #(
        .DEPTH  (256),
        .RD_LAT (0),
        .WR_LAT (1)
    ) u_b (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MEM_PARITY_EN
        .inj_par_err (b_inj),
`endif
        .req         (b_req),
        .rnw         (b_rnw),
        .addr        (b_addr),
        .wdata       (b_wdata),
        .rdata       (b_rdata),
        .ready       (b_ready),
        .busy        (b_busy),
        .err         (b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic r, input logic rw,
                         input logic [11:0] a, input logic [15:0] d, input logic inj);
        if (inst == 0) begin
            a_req = r; a_rnw = rw; a_addr = a; a_wdata = d;
`ifdef MEM_PARITY_EN
            a_inj = inj;
`endif
        end else begin
            b_req = r; b_rnw = rw; b_addr = a; b_wdata = d;
`ifdef MEM_PARITY_EN
            b_inj = inj;
`endif
        end
    endtask

    function automatic logic get_ready(input int inst);
        return (inst == 0) ? a_ready : b_ready;
    endfunction
    function automatic logic get_busy(input int inst);
        return (inst == 0) ? a_busy : b_busy;
    endfunction
    function automatic logic get_err(input int inst);
        return (inst == 0) ? a_err : b_err;
    endfunction
    function automatic logic [15:0] get_rdata(input int inst);
        return (inst == 0) ? a_rdata : b_rdata;
    endfunction

    // One handshake: present request, check latency, err, rdata and return to IDLE.
    task automatic txn(input int inst, input bit rnw, input logic [11:0] addr,
                       input logic [15:0] wd, input bit inj, input int lat,
                       input bit exp_err, input logic [15:0] exp_rd, input string tag);
        int cyc;
        bit got;
        @(negedge clk);
        drive(inst, 1'b1, rnw, addr, wd, inj);
        @(posedge clk); #1;                       // acceptance edge E0
        // Inputs are free to change after acceptance.
        drive(inst, 1'b0, 1'($urandom_range(0, 1)), 12'($urandom), 16'($urandom), 1'b0);
        check({tag, " busy_after_accept"}, 32'(get_busy(inst)), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            got = get_ready(inst);
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat + 1));
        check({tag, " err"}, 32'(get_err(inst)), 32'(exp_err));
        check({tag, " rdata"}, 32'(get_rdata(inst)), 32'(exp_rd));
        @(posedge clk); #1;
        check({tag, " ready_one_cycle"}, 32'(get_ready(inst)), 32'd0);
        check({tag, " idle_after"}, 32'(get_busy(inst)), 32'd0);
        $display("txn %s inst=%0d %s addr=%03h wdata=%04h rdata=%04h err=%0b lat=%0d",
                 tag, inst, rnw ? "RD" : "WR", addr, wd, get_rdata(inst), exp_err, cyc - 1);
    endtask

    // Expected results derived from the model, then the model is updated.
    task automatic model_txn(input int inst, input bit rnw, input logic [11:0] addr,
                             input logic [15:0] wd, input bit inj, input string tag);
        int          depth;
        bit          oob;
        int          lat;
        bit          stored_bad;
        logic [15:0] exp_rd;
        depth      = (inst == 0) ? 4096 : 256;
        oob        = (int'(addr) >= depth);
        lat        = rnw ? ((inst == 0) ? 2 : 0) : 1;
        stored_bad = 1'b0;
        exp_rd     = hold_rd[inst];
        if (rnw) begin
            if (oob) begin
                exp_rd = 16'h0000;
            end else if (inst == 0) begin
                exp_rd = mem_a[int'(addr)];
                stored_bad = bad_a[int'(addr)];
            end else begin
                exp_rd = mem_b[int'(addr)];
                stored_bad = bad_b[int'(addr)];
            end
        end
        txn(inst, rnw, addr, wd, inj, lat, oob || (PAR_EN && rnw && stored_bad), exp_rd, tag);
        if (rnw) begin
            hold_rd[inst] = exp_rd;
        end else if (!oob) begin
            if (inst == 0) begin
                mem_a[int'(addr)] = wd; bad_a[int'(addr)] = inj; wr_a.push_back(int'(addr));
            end else begin
                mem_b[int'(addr)] = wd; bad_b[int'(addr)] = inj; wr_b.push_back(int'(addr));
            end
        end
    endtask

    initial begin
        hold_rd[0] = 16'h0000;
        hold_rd[1] = 16'h0000;
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 12'h010, 16'hAAAA, 1'b0);
        drive(1, 1'b1, 1'b1, 12'h010, 16'h5555, 1'b0);

        // ---- reset with req held high ----
        repeat (3) @(posedge clk);
        #1;
        check("rst a_rdata", 32'(a_rdata), 32'd0);
        check("rst a_ready", 32'(a_ready), 32'd0);
        check("rst a_busy",  32'(a_busy),  32'd0);
        check("rst a_err",   32'(a_err),   32'd0);
        check("rst b_rdata", 32'(b_rdata), 32'd0);
        check("rst b_ready", 32'(b_ready), 32'd0);
        check("rst b_busy",  32'(b_busy),  32'd0);
        check("rst b_err",   32'(b_err),   32'd0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
        drive(1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst a_busy", 32'(a_busy), 32'd0);
        check("post_rst b_busy", 32'(b_busy), 32'd0);

        // ---- write then read, RD_LAT=2 / WR_LAT=1 ----
        model_txn(0, 1'b0, 12'h064, 16'h4444, 1'b0, "wr064");
        model_txn(0, 1'b1, 12'h064, 16'h0000, 1'b0, "rd064");
        model_txn(0, 1'b0, 12'hFFF, 16'h7E57, 1'b0, "wr_top");
        model_txn(0, 1'b1, 12'hFFF, 16'h0000, 1'b0, "rd_top");

        // ---- zero read latency, req held high through RESP ----
        model_txn(1, 1'b0, 12'h065, 16'h2222, 1'b0, "b_wr065");
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 12'h065, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("held busy_E0", 32'(b_busy), 32'd1);
        @(posedge clk); #1;
        check("held ready_E1", 32'(b_ready), 32'd1);
        check("held rdata_E1", 32'(b_rdata), 32'h2222);
        @(posedge clk); #1;
        check("held idle_E2", 32'(b_busy), 32'd0);
        check("held noready_E2", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        check("held reaccept_E3", 32'(b_busy), 32'd1);
        drive(1, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("held ready_E4", 32'(b_ready), 32'd1);
        check("held rdata_E4", 32'(b_rdata), 32'h2222);
        @(posedge clk); #1;
        check("held idle_E5", 32'(b_busy), 32'd0);
        $display("txn held_req inst=1 two reads of 065 rdata=%04h", b_rdata);
        hold_rd[1] = 16'h2222;

        // ---- range, DEPTH=256 ----
        model_txn(1, 1'b0, 12'h000, 16'h1357, 1'b0, "b_wr000");
        model_txn(1, 1'b0, 12'h100, 16'hBEEF, 1'b0, "b_wr100_oob");
        model_txn(1, 1'b1, 12'h000, 16'h0000, 1'b0, "b_rd000");
        model_txn(1, 1'b1, 12'h100, 16'h0000, 1'b0, "b_rd100_oob");
        model_txn(1, 1'b1, 12'h000, 16'h0000, 1'b0, "b_rd000_again");
        model_txn(1, 1'b0, 12'h0FF, 16'h00FF, 1'b0, "b_wr0ff");
        model_txn(1, 1'b1, 12'h0FF, 16'h0000, 1'b0, "b_rd0ff");

        // ---- reset mid-write ----
        model_txn(0, 1'b0, 12'h066, 16'h2282, 1'b0, "wr066_pre");
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 12'h066, 16'h1111, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0);
        check("midrst busy_before", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(a_busy), 32'd0);
        check("midrst ready", 32'(a_ready), 32'd0);
        check("midrst rdata", 32'(a_rdata), 32'd0);
        @(posedge clk); #1;
        check("midrst ready_edge", 32'(a_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_rd[0] = 16'h0000;
        hold_rd[1] = 16'h0000;
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst no_ready", 32'(a_ready), 32'd0);
        end
        $display("txn midrst inst=0 WR addr=066 aborted");
        model_txn(0, 1'b1, 12'h066, 16'h0000, 1'b0, "rd066_after_rst");

`ifdef MEM_PARITY_EN
        // ---- injected parity error ----
        model_txn(0, 1'b0, 12'h024, 16'h2332, 1'b1, "par_wr_bad");
        model_txn(0, 1'b1, 12'h024, 16'h0000, 1'b0, "par_rd_bad");
        model_txn(0, 1'b0, 12'h024, 16'h2332, 1'b0, "par_wr_good");
        model_txn(0, 1'b1, 12'h024, 16'h0000, 1'b0, "par_rd_good");
`endif

        // ---- randomized traffic against the model ----
        for (int inst = 0; inst < 2; inst++) begin
            for (int n = 0; n < 20; n++) begin
                bit          rd;
                bit          inj;
                logic [11:0] ad;
                rd  = 1'($urandom_range(0, 1));
                inj = PAR_EN && ($urandom_range(0, 3) == 0);
                if (rd) begin
                    if (inst == 1 && $urandom_range(0, 4) == 0) begin
                        ad = 12'($urandom_range(256, 4095));
                    end else if (inst == 0) begin
                        ad = 12'(wr_a[$urandom_range(0, wr_a.size() - 1)]);
                    end else begin
                        ad = 12'(wr_b[$urandom_range(0, wr_b.size() - 1)]);
                    end
                end else if (inst == 1 && $urandom_range(0, 4) == 0) begin
                    ad = 12'($urandom_range(256, 4095));
                end else begin
                    ad = 12'($urandom_range(0, (inst == 0) ? 4095 : 255));
                end
                model_txn(inst, rd, ad, 16'($urandom), inj, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
